// File: rtl/rns_pkg.sv
// Shared definitions for the RNS modular add/subtract pipeline.
//   op_e            : operation encoding carried on in_op
//   DEF_DATA_WIDTH  : default residue width per channel
//   DEF_NUM_CH      : default number of residue channels
//   DEF_MODULUS     : default per-channel modulus (3^11)
package rns_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,  // A + B  mod M
        OP_SUB  = 2'b01,  // A - B  mod M
        OP_ADDK = 2'b10,  // A + K  mod M
        OP_SUBK = 2'b11   // A - K  mod M
    } op_e;

    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_MODULUS    = 177147;

endpackage

// File: rtl/rns_mod_addsub_lane.sv
// One residue channel of the modular add/subtract pipeline.
// Stage 1 registers the raw sum/difference and its modulus-corrected
// candidate; stage 2 registers the selected residue (forced to 0 when the
// operands were out of range).
//   clk, reset : clock, asynchronous active-high reset
//   en         : global pipe enable; both stages hold when low
//   a, bop     : operand A and second operand (B or K)
//   is_sub     : 1 = subtract, 0 = add
//   chk_b      : 1 = range-check bop as well as a
//   result     : registered residue (stage 2)
//   range_err  : registered operand-out-of-range flag (stage 2)
module rns_mod_addsub_lane
    import rns_pkg::*;
#(
    parameter int           W = DEF_DATA_WIDTH,
    parameter logic [W-1:0] M = W'(DEF_MODULUS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] bop,
    input  logic         is_sub,
    input  logic         chk_b,
    output logic [W-1:0] result,
    output logic         range_err
);

    // Two extra bits: one for the carry of A+B, one for the sign of A-B / S-M.
    localparam int XW = W + 2;

    logic [XW-1:0] a_x, b_x, m_x;
    logic [XW-1:0] raw_d, cand_d;
    logic          err_d;

    logic [XW-1:0] s1_raw, s1_cand;
    logic          s1_sub, s1_err;

    logic [XW-1:0] sel;
    logic          sel_unused;

    assign a_x = {2'b00, a};
    assign b_x = {2'b00, bop};
    assign m_x = {2'b00, M};

    always_comb begin
        raw_d  = is_sub ? (a_x - b_x) : (a_x + b_x);
        // Add: candidate is S-M; Sub: candidate is D+M.
        cand_d = is_sub ? (raw_d + m_x) : (raw_d - m_x);
        err_d  = (a >= M) || (chk_b && (bop >= M));
    end

    // Add keeps S-M unless it went negative; Sub keeps D unless it went negative.
    always_comb begin
        if (s1_sub) begin
            sel = s1_raw[XW-1] ? s1_cand : s1_raw;
        end else begin
            sel = s1_cand[XW-1] ? s1_raw : s1_cand;
        end
    end

    // Upper bits of the selected value are zero for in-range operands.
    assign sel_unused = ^sel[XW-1:W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_raw    <= '0;
            s1_cand   <= '0;
            s1_sub    <= 1'b0;
            s1_err    <= 1'b0;
            result    <= '0;
            range_err <= 1'b0;
        end else if (en) begin
            s1_raw    <= raw_d;
            s1_cand   <= cand_d;
            s1_sub    <= is_sub;
            s1_err    <= err_d;
            result    <= s1_err ? '0 : sel[W-1:0];
            range_err <= s1_err;
        end
    end

endmodule

// File: rtl/rns_mod_addsub_pipe.sv
// Multi-channel RNS modular add/subtract pipeline, 2-cycle fixed latency.
// Handshake: a beat transfers on in_valid && in_ready and a result on
// out_valid && out_ready; in_ready = out_ready || !s2_valid is the single
// pipe enable, so both stages advance or hold together.
//   clk, reset     : clock, asynchronous active-high reset
//   in_valid/ready : operand beat handshake
//   in_op          : op_e encoding (A+B, A-B, A+K, A-K)
//   in_a, in_b     : packed per-channel operands, channel 0 in LSBs
//   cfg_we/ch/const: write constant K for one channel
//   cfg_err        : one-cycle pulse when a write is rejected
//   out_valid/ready: result handshake
//   out_result     : packed per-channel residues
//   out_range_err  : per-channel operand-out-of-range flags
module rns_mod_addsub_pipe
    import rns_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter logic [NUM_CH*DATA_WIDTH-1:0] MODULI = {NUM_CH{18'd177147}},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_a,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_b,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [DATA_WIDTH-1:0]        cfg_const,
    output logic                         cfg_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_result,
    output logic [NUM_CH-1:0]            out_range_err
);

    op_e  op;
    logic use_k, is_sub, en;
    logic s1_valid, s2_valid;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] k_reg;
    logic                              ch_hit, cfg_ok;
    logic [DATA_WIDTH-1:0]             ch_mod;

    assign op       = op_e'(in_op);
    assign use_k    = (op == OP_ADDK) || (op == OP_SUBK);
    assign is_sub   = (op == OP_SUB)  || (op == OP_SUBK);
    assign in_ready = out_ready || !s2_valid;
    assign en       = in_ready;
    assign out_valid = s2_valid;

    // Valid pipe; bubbles travel like beats so latency stays fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    // Channel decode by match so a non-power-of-two NUM_CH rejects the gaps.
    always_comb begin
        ch_hit = 1'b0;
        ch_mod = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_hit = 1'b1;
                ch_mod = MODULI[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cfg_ok = ch_hit && (cfg_const < ch_mod);
    end

    // K updates independently of the pipe enable; a beat accepted on the
    // same edge samples the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && cfg_ok && (cfg_ch == CH_W'(i))) begin
                    k_reg[i] <= cfg_const;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        rns_mod_addsub_lane #(
            .W (DATA_WIDTH),
            .M (MODULI[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .a         (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .bop       (use_k ? k_reg[i] : in_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .is_sub    (is_sub),
            .chk_b     (!use_k),
            .result    (out_result[i*DATA_WIDTH +: DATA_WIDTH]),
            .range_err (out_range_err[i])
        );
    end

endmodule

// File: tb/tb_rns_mod_addsub_pipe.sv
module tb_rns_mod_addsub_pipe;
    import rns_pkg::*;

    localparam int DW  = 18;
    localparam int NC  = 4;
    localparam int MOD = 177147;
    localparam int EW  = NC*DW + NC;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [NC*DW-1:0] in_a, in_b;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [DW-1:0]   cfg_const;
    logic            cfg_err;
    logic            out_valid;
    logic            out_ready;
    logic [NC*DW-1:0] out_result;
    logic [NC-1:0]   out_range_err;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0]          exp_q[$];
    logic [NC-1:0][DW-1:0]  k_model;
    logic                   exp_cfg_err;
    logic                   have_hold;
    logic [EW:0]            held;
    logic                   rand_done;

    rns_mod_addsub_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_const     (cfg_const),
        .cfg_err       (cfg_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_range_err (out_range_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*DW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
        logic [NC*DW-1:0] r;
        r = {DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
        return r;
    endfunction

    // Reference: plain modular arithmetic on integers.
    function automatic logic [EW-1:0] model_beat(input logic [1:0] op, input logic [NC*DW-1:0] a,
                                                 input logic [NC*DW-1:0] b, input logic [NC-1:0][DW-1:0] k);
        logic [NC*DW-1:0] res;
        logic [NC-1:0]    err;
        int av, bv, r;
        res = '0;
        err = '0;
        for (int ch = 0; ch < NC; ch++) begin
            av = int'(a[ch*DW +: DW]);
            bv = op[1] ? int'(k[ch]) : int'(b[ch*DW +: DW]);
            if (av >= MOD || (!op[1] && bv >= MOD)) begin
                err[ch] = 1'b1;
                r = 0;
            end else if (!op[0]) begin
                r = (av + bv) % MOD;
            end else begin
                r = (av - bv + MOD) % MOD;
            end
            res[ch*DW +: DW] = DW'(r);
        end
        return {err, res};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            k_model     = '0;
            exp_cfg_err = 1'b0;
            have_hold   = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out", {out_range_err, out_result}, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_cfg_err", cfg_err, 0);
        end else begin
            chk("cfg_err", cfg_err, exp_cfg_err);
            chk("in_ready", in_ready, out_ready || !out_valid);
            if (have_hold) chk("stall_hold", {out_valid, out_range_err, out_result}, held);
            if (out_valid && out_ready) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_beat", {out_range_err, out_result}, exp_q.pop_front());
            end
            have_hold = out_valid && !out_ready;
            held      = {out_valid, out_range_err, out_result};
            // beat first: a coincident config write is not yet visible to it
            if (in_valid && in_ready) exp_q.push_back(model_beat(in_op, in_a, in_b, k_model));
            exp_cfg_err = 1'b0;
            if (cfg_we) begin
                if (int'(cfg_ch) < NC && int'(cfg_const) < MOD) k_model[cfg_ch] = cfg_const;
                else exp_cfg_err = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [NC*DW-1:0] a, input logic [NC*DW-1:0] b);
        logic acc;
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic cfg_write(input int ch, input int val);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_const = DW'(val);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Pipe empty, beat just accepted: out_valid low next cycle, high the one after.
    task automatic check_lat(input int ch, input int exp_val, input logic exp_err);
        @(negedge clk);
        chk("lat_not_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lit_result", out_result[ch*DW +: DW], exp_val);
        chk("lit_err", out_range_err[ch], exp_err);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_const = '0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Model pins, hand-computed.
        chk("pin_add_wrap", model_beat(OP_ADD, pk(177146, 0, 0, 0), pk(1, 0, 0, 0), '0), {4'b0000, pk(0, 0, 0, 0)});
        chk("pin_sub_neg", model_beat(OP_SUB, pk(5, 7, 0, 0), pk(7, 5, 0, 0), '0), {4'b0000, pk(177145, 2, 0, 0)});

        // Wrap-around add, boundary M-1 + M-1, first-beat latency.
        send(OP_ADD, pk(177146, 177146, 0, 100000), pk(1, 177146, 0, 100000));
        @(negedge clk);
        chk("lat_not_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("add_wrap_ch0", out_result[0 +: DW], 0);
        chk("add_max_ch1", out_result[DW +: DW], 177145);
        chk("add_ch3", out_result[3*DW +: DW], 22853);
        chk("add_err", out_range_err, 4'b0000);
        @(posedge clk);
        #1;

        // Subtraction both signs.
        send(OP_SUB, pk(5, 7, 0, 177146), pk(7, 5, 177146, 0));
        check_lat(0, 177145, 1'b0);
        send(OP_SUB, pk(7, 0, 0, 0), pk(5, 0, 0, 0));
        check_lat(0, 2, 1'b0);

        // Constant register: write, use, rejected write.
        cfg_write(0, 100);
        send(OP_ADDK, pk(177100, 9, 0, 0), pk(0, 0, 0, 0));
        check_lat(0, 53, 1'b0);
        cfg_write(0, 177147);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        @(posedge clk);
        #1;
        send(OP_ADDK, pk(177100, 0, 0, 0), pk(0, 0, 0, 0));
        check_lat(0, 53, 1'b0);
        send(OP_SUBK, pk(50, 0, 0, 0), pk(0, 0, 0, 0));
        check_lat(0, 177097, 1'b0);

        // Write coincident with a beat on the same channel: beat sees old K.
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_const = 18'd7;
        send(OP_ADDK, pk(1, 0, 0, 0), pk(0, 0, 0, 0));
        cfg_we = 1'b0;
        check_lat(0, 101, 1'b0);
        send(OP_ADDK, pk(1, 0, 0, 0), pk(0, 0, 0, 0));
        check_lat(0, 8, 1'b0);

        // Range errors: only channel 1 flagged and zeroed.
        send(OP_ADD, pk(1, 177147, 3, 0), pk(2, 0, 4, 0));
        @(negedge clk);
        @(negedge clk);
        chk("rerr_flags", out_range_err, 4'b0010);
        chk("rerr_ch1", out_result[DW +: DW], 0);
        chk("rerr_ch0", out_result[0 +: DW], 3);
        chk("rerr_ch2", out_result[2*DW +: DW], 7);
        @(posedge clk);
        #1;
        // B is not range-checked for K ops.
        send(OP_ADDK, pk(1, 0, 0, 0), pk(262143, 262143, 0, 0));
        check_lat(0, 8, 1'b0);

        // Six-beat stream with a 3-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'(i % 2), pk(i*1000, 177146 - i, i, 5), pk(7, i*3, 177140, i));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random mix with random backpressure and config writes.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        cfg_write($urandom_range(0, 3),
                                  ($urandom_range(0, 2) == 0) ? $urandom_range(MOD, 262143) : $urandom_range(0, MOD - 1));
                    end else begin
                        send(2'($urandom_range(0, 3)),
                             pk(($urandom_range(0, 15) == 0) ? MOD : $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                                $urandom_range(0, MOD - 1), $urandom_range(MOD - 3, MOD - 1)),
                             pk($urandom_range(0, MOD - 1), ($urandom_range(0, 15) == 0) ? 262143 : $urandom_range(0, MOD - 1),
                                $urandom_range(0, MOD - 1), $urandom_range(MOD - 3, MOD - 1)));
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        cfg_write(0, 100);
        out_ready = 1'b0;
        send(OP_ADD, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        send(OP_ADD, pk(2, 2, 2, 2), pk(2, 2, 2, 2));
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out", {out_range_err, out_result}, 0);
        chk("async_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ghost", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(OP_ADDK, pk(5, 0, 0, 0), pk(0, 0, 0, 0));
        check_lat(0, 5, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
